// File: rtl/qmux_switch_ctrl_if.sv
// Handshake and control bundle for qmux_switch_ctrl.
// master: drives the enables and select requests, observes mux controls.
// slave : the controller; drives REQ_READY, SELECT, GATE_EN, BUSY, DONE, ERR.
interface qmux_switch_ctrl_if #(
  parameter int SEL_W = 2
);
  logic             SEN;
  logic             DEN;
  logic             DYNEN;
  logic             REQ_VALID;
  logic [SEL_W-1:0] REQ_SEL;
  logic             REQ_READY;
  logic [SEL_W-1:0] SELECT;
  logic             GATE_EN;
  logic             BUSY;
  logic             DONE;
  logic             ERR;

  modport master (
    output SEN, DEN, DYNEN, REQ_VALID, REQ_SEL,
    input  REQ_READY, SELECT, GATE_EN, BUSY, DONE, ERR
  );

  modport slave (
    input  SEN, DEN, DYNEN, REQ_VALID, REQ_SEL,
    output REQ_READY, SELECT, GATE_EN, BUSY, DONE, ERR
  );
endinterface

// File: rtl/qmux_switch_ctrl.sv
// Sequenced select/gate controller for an N-input clock mux.
// Switches use break-before-make: gate off, GAP_CYC dead cycles, select
// update, GAP_CYC settle cycles, gate on.
// Ports:
//   QCK  - control clock (rising edge)
//   QRT  - asynchronous active-high reset
//   bus  - slave side of qmux_switch_ctrl_if (enables, request handshake,
//          registered SELECT/GATE_EN/BUSY/DONE/ERR, combinational REQ_READY)
module qmux_switch_ctrl #(
  parameter int N_SRC     = 4,
  parameter int SEL_W     = $clog2(N_SRC),
  parameter int GAP_CYC   = 3,
  parameter int RESET_SEL = 0
) (
  input logic               QCK,
  input logic               QRT,
  qmux_switch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_DIS, S_SET, S_EN, S_DRN} state_t;

  localparam logic [3:0]       CNT_INIT = 4'(GAP_CYC - 1);
  // One extra bit so N_SRC itself is representable when it is a power of two.
  localparam logic [SEL_W:0]   N_LIM    = (SEL_W + 1)'(N_SRC);
  localparam logic [SEL_W-1:0] SEL_RST  = SEL_W'(RESET_SEL);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] tgt_q, tgt_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             gate_q, gate_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic act, ready, accept, bad;

  always_comb begin
    act    = bus.SEN & ~bus.DEN;
    ready  = bus.DYNEN & ((state_q == S_EN) | (state_q == S_DIS));
    // Deactivation wins over a request on the same edge.
    accept = bus.REQ_VALID & ready & act;
    bad    = {1'b0, bus.REQ_SEL} >= N_LIM;

    state_d = state_q;
    sel_d   = sel_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (!act) begin
      state_d = S_DIS;
      cnt_d   = '0;
      // Gate is already off while draining, so the pending select can land now.
      if (state_q == S_DRN) sel_d = tgt_q;
    end else begin
      if (accept && bad) err_d = 1'b1;
      case (state_q)
        S_DIS: begin
          if (accept && !bad) sel_d = bus.REQ_SEL;
          state_d = S_SET;
          cnt_d   = CNT_INIT;
        end
        S_EN: begin
          if (accept && !bad && (bus.REQ_SEL != sel_q)) begin
            tgt_d   = bus.REQ_SEL;
            state_d = S_DRN;
            cnt_d   = CNT_INIT;
          end
        end
        S_DRN: begin
          if (cnt_q == '0) begin
            sel_d   = tgt_q;
            state_d = S_SET;
            cnt_d   = CNT_INIT;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_SET: begin
          if (cnt_q == '0) begin
            state_d = S_EN;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = S_DIS;
      endcase
    end

    gate_d = (state_d == S_EN);
    busy_d = (state_d == S_DRN) | (state_d == S_SET);
  end

  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      state_q <= S_DIS;
      sel_q   <= SEL_RST;
      tgt_q   <= SEL_RST;
      cnt_q   <= '0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.REQ_READY = ready;
  assign bus.SELECT    = sel_q;
  assign bus.GATE_EN   = gate_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.ERR       = err_q;

endmodule

// File: tb/tb_qmux_switch_ctrl.sv
// Bench for qmux_switch_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a countdown model.
module tb_qmux_switch_ctrl;
  localparam int N  = 4;
  localparam int SW = 3;   // wide enough to express out-of-range requests
  localparam int G  = 3;

  logic QCK = 1'b0;
  logic QRT = 1'b1;

  qmux_switch_ctrl_if #(.SEL_W(SW)) bus ();

  qmux_switch_ctrl #(.N_SRC(N), .SEL_W(SW), .GAP_CYC(G), .RESET_SEL(0)) dut (
    .QCK (QCK),
    .QRT (QRT),
    .bus (bus)
  );

  always #5 QCK = ~QCK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Model: m_on = sequence active (ACT seen), m_left = edges until the gate
  // opens. A switch loads 2G; the select lands when m_left reaches G.
  bit m_on, m_done, m_err, m_act, m_acc;
  int m_left, m_sel, m_tgt, m_rs;

  function automatic bit m_ready();
    return bus.DYNEN && (!m_on || m_left == 0);
  endfunction

  always @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      m_on = 0; m_left = 0; m_sel = 0; m_tgt = 0; m_done = 0; m_err = 0;
    end else begin
      m_act  = bus.SEN && !bus.DEN;
      m_acc  = bus.REQ_VALID && m_ready() && m_act;
      m_rs   = int'(bus.REQ_SEL);
      m_done = 0;
      m_err  = 0;
      if (!m_act) begin
        if (m_on && m_left > G) m_sel = m_tgt;
        m_on = 0; m_left = 0;
      end else begin
        if (m_acc && m_rs >= N) m_err = 1;
        if (!m_on) begin
          if (m_acc && m_rs < N) m_sel = m_rs;
          m_on = 1; m_left = G;
        end else if (m_left > 0) begin
          m_left--;
          if (m_left == G) m_sel = m_tgt;
          if (m_left == 0) m_done = 1;
        end else if (m_acc && m_rs < N && m_rs != m_sel) begin
          m_tgt = m_rs; m_left = 2 * G;
        end
      end
    end
  end

  always @(negedge QCK) begin
    chk("m_select",  int'(bus.SELECT),    m_sel);
    chk("m_gate_en", int'(bus.GATE_EN),   int'(m_on && m_left == 0));
    chk("m_busy",    int'(bus.BUSY),      int'(m_on && m_left > 0));
    chk("m_done",    int'(bus.DONE),      int'(m_done));
    chk("m_err",     int'(bus.ERR),       int'(m_err));
    chk("m_ready",   int'(bus.REQ_READY), int'(m_ready()));
  end

  task automatic step();
    @(negedge QCK);
    #1;
  endtask

  initial begin
    bus.SEN = 1; bus.DEN = 0; bus.DYNEN = 0; bus.REQ_VALID = 0; bus.REQ_SEL = '0;
    repeat (2) step();
    chk("rst_select", int'(bus.SELECT), 0);
    chk("rst_gate", int'(bus.GATE_EN), 0);
    chk("rst_busy", int'(bus.BUSY), 0);
    QRT = 0;
    step(); chk("act_e1_gate", int'(bus.GATE_EN), 0); chk("act_e1_busy", int'(bus.BUSY), 1);
    step(); step(); chk("act_e3_gate", int'(bus.GATE_EN), 0);
    step(); chk("act_e4_gate", int'(bus.GATE_EN), 1); chk("act_e4_done", int'(bus.DONE), 1);
    step(); chk("act_e5_done", int'(bus.DONE), 0);

    // switch to 2
    bus.DYNEN = 1; bus.REQ_VALID = 1; bus.REQ_SEL = 3'd2; #1;
    chk("sw_ready", int'(bus.REQ_READY), 1);
    step(); bus.REQ_VALID = 0; #1;
    chk("sw_e0_gate", int'(bus.GATE_EN), 0); chk("sw_e0_ready", int'(bus.REQ_READY), 0);
    step(); step(); chk("sw_e2_sel", int'(bus.SELECT), 0);
    step(); chk("sw_e3_sel", int'(bus.SELECT), 2);
    step(); step(); chk("sw_e5_gate", int'(bus.GATE_EN), 0); chk("sw_e5_ready", int'(bus.REQ_READY), 0);
    step(); chk("sw_e6_gate", int'(bus.GATE_EN), 1); chk("sw_e6_done", int'(bus.DONE), 1);

    // same-select no-op
    bus.REQ_VALID = 1; bus.REQ_SEL = 3'd2;
    step(); bus.REQ_VALID = 0;
    chk("noop_gate", int'(bus.GATE_EN), 1); chk("noop_busy", int'(bus.BUSY), 0);
    step(); chk("noop_done", int'(bus.DONE), 0);

    // out-of-range request
    bus.REQ_VALID = 1; bus.REQ_SEL = 3'd5;
    step(); bus.REQ_VALID = 0;
    chk("err_pulse", int'(bus.ERR), 1); chk("err_sel", int'(bus.SELECT), 2);
    step(); chk("err_clear", int'(bus.ERR), 0);

    // deactivate while draining toward 3
    bus.REQ_VALID = 1; bus.REQ_SEL = 3'd3;
    step(); bus.REQ_VALID = 0;
    step(); bus.DEN = 1;
    step(); chk("drn_off_sel", int'(bus.SELECT), 3); chk("drn_off_gate", int'(bus.GATE_EN), 0);
    chk("drn_off_busy", int'(bus.BUSY), 0);
    bus.DEN = 0;
    step(); step(); step(); chk("react_e3_gate", int'(bus.GATE_EN), 0);
    step(); chk("react_gate", int'(bus.GATE_EN), 1); chk("react_done", int'(bus.DONE), 1);

    // DYNEN=0 blocks requests
    bus.DYNEN = 0; bus.REQ_VALID = 1; bus.REQ_SEL = 3'd1; #1;
    chk("dyn0_ready", int'(bus.REQ_READY), 0);
    step(); chk("dyn0_sel", int'(bus.SELECT), 3); chk("dyn0_busy", int'(bus.BUSY), 0);
    bus.REQ_VALID = 0;

    // direct select from DISABLED on the re-activation edge
    bus.DEN = 1;
    step();
    bus.DYNEN = 1; bus.DEN = 0; bus.REQ_VALID = 1; bus.REQ_SEL = 3'd1;
    step(); bus.REQ_VALID = 0;
    chk("dis_sel", int'(bus.SELECT), 1); chk("dis_gate", int'(bus.GATE_EN), 0);

    // async reset mid-settle
    step();
    QRT = 1; #1;
    chk("arst_sel", int'(bus.SELECT), 0); chk("arst_gate", int'(bus.GATE_EN), 0);
    chk("arst_busy", int'(bus.BUSY), 0); chk("arst_done", int'(bus.DONE), 0);
    step(); QRT = 0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      QRT           = ($urandom_range(0, 299) == 0);
      bus.SEN       = ($urandom_range(0, 49) != 0);
      bus.DEN       = ($urandom_range(0, 39) == 0);
      bus.DYNEN     = ($urandom_range(0, 9) != 0);
      bus.REQ_VALID = ($urandom_range(0, 2) == 0);
      bus.REQ_SEL   = SW'($urandom_range(0, 5));
    end
    step(); QRT = 0;
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/qmux_switch_ctrl.md
# qmux_switch_ctrl

Parametrised, sequenced controller for an N-input quadrant clock mux. It accepts dynamic source-select requests through a valid/ready handshake. Each switch uses a break-before-make sequence: gate off, dead time, select update, settle time, gate on. The static enable and disable terms gate the output exactly as the single-mux primitive does. The block sits in the clock-network control fabric and drives the select and enable pins of the downstream clock mux/gate.

## Interface
Parameters:
- N_SRC, 4: number of selectable clock sources (2..16).
- SEL_W, $clog2(N_SRC): select width.
- GAP_CYC, 3: dead/settle time in QCK cycles (1..15).
- RESET_SEL, 0: select value after reset (< N_SRC).

Ports:
- QCK  in  1  control clock, free-running, rising edge.
- QRT  in  1  reset, asynchronous, active-high.
- SEN  in  1  static enable; output path active only when SEN=1 and DEN=0.
- DEN  in  1  disable; 1 forces the gate off.
- DYNEN  in  1  dynamic-select mode; 0 blocks all requests.
- REQ_VALID  in  1  select request valid.
- REQ_SEL  in  SEL_W  requested source.
- REQ_READY  out  1  request can be accepted.
- SELECT  out  SEL_W  mux select, registered.
- GATE_EN  out  1  clock gate enable, registered.
- BUSY  out  1  switch sequence in progress.
- DONE  out  1  one-cycle pulse when the gate re-opens after a switch or re-activation.
- ERR  out  1  one-cycle pulse when an out-of-range request is accepted.

## Operation
- ACT = SEN & ~DEN. Sampled every QCK edge.
- States:
  - DISABLED: GATE_EN=0.
  - SETTLE: GATE_EN=0, counting.
  - ENABLED: GATE_EN=1.
  - DRAIN: GATE_EN=0, counting.
- Reset (QRT=1) sets state=DISABLED, SELECT=RESET_SEL, target=RESET_SEL, cnt=0, and GATE_EN=BUSY=DONE=ERR=0.
- REQ_READY = DYNEN & (state==ENABLED | state==DISABLED). It is combinational from state and DYNEN.
- Accept condition: REQ_VALID & REQ_READY at a QCK edge.
  - If REQ_SEL >= N_SRC: ERR=1 for the next cycle. No other change.
  - Else if state==DISABLED: SELECT <= REQ_SEL directly, with no gap.
  - Else if REQ_SEL == SELECT: the request is consumed as a no-op. No gate drop, no DONE.
  - Else: target <= REQ_SEL, state <= DRAIN, cnt <= GAP_CYC-1.
- Transitions:
  - DISABLED -> SETTLE when ACT=1, cnt <= GAP_CYC-1.
  - DRAIN: cnt decrements each cycle. At cnt==0, SELECT <= target, state <= SETTLE, cnt <= GAP_CYC-1.
  - SETTLE: cnt decrements each cycle. At cnt==0, state <= ENABLED and DONE=1 for the next cycle.
  - ENABLED holds until an accepted switch or ACT=0.
- ACT=0 in any state: the next state is DISABLED and cnt is cleared. If the state was DRAIN, SELECT <= target on that edge, because the gate is already off. ACT=0 takes priority over a request on the same edge, and that request is not accepted.
- BUSY = state in {DRAIN, SETTLE}.
- DYNEN falling mid-sequence does not abort it. It only blocks new requests.

## Timing
- All outputs registered except REQ_READY.
- Switch latency, with an accept at edge E0 and G=GAP_CYC:
  - GATE_EN low after E0.
  - SELECT changes after E(G).
  - GATE_EN high and DONE pulse after E(2G).
- GATE_EN is low for exactly 2G cycles. SELECT never changes while GATE_EN=1.
- Re-activation: ACT rising at edge Ea gives GATE_EN=1 and DONE after Ea+G.
- Asynchronous QRT mid-sequence immediately forces the reset values. No DONE follows.

## Test plan
- Reset with SEN=1, DEN=0, G=3 -> SELECT=0 and GATE_EN=0 during reset; GATE_EN=1 and DONE pulse 3 cycles after the first edge with QRT released.
- In ENABLED, accept REQ_SEL=2 at E0 -> GATE_EN=0 after E0; SELECT=2 after E3; GATE_EN=1 and DONE=1 after E6; REQ_READY=0 in E1..E5.
- REQ_SEL=1 while SELECT=1 -> accepted, no gate drop, no DONE. REQ_SEL=5 with N_SRC=4 -> ERR pulse for 1 cycle, SELECT unchanged.
- DEN=1 asserted during DRAIN (target=3) -> next cycle DISABLED, SELECT=3, GATE_EN=0. DEN=0 -> GATE_EN=1 after 3 cycles.
- DYNEN=0 with REQ_VALID=1 -> REQ_READY=0, no state change. In DISABLED with DYNEN=1, REQ_SEL=3 -> SELECT=3 the next cycle, GATE_EN stays 0.
- QRT pulse mid-SETTLE -> all outputs return to reset values immediately, SELECT=RESET_SEL.
